ex_alu_stage: RTL

Execute stage of the pipelined CPU. Consumes the 4-bit ALU control code from the ALU control decoder plus the ID/EX operands and control bits. Computes the ALU result and flags, then holds them in a one-entry EX/MEM output register with a valid/ready handshake, flush, and writeback suppression on overflow or illegal codes.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 59 +++++
 rtl/ex_alu_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths and EX FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_REG_W  = 5;

    // ALU control codes, also produced by the ALU control decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_LW  = 4'b0101;
    localparam logic [3:0] ALU_SW  = 4'b0110;
    localparam logic [3:0] ALU_BEQ = 4'b0111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, zero, signed-overflow and illegal-code flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage decides when to capture.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [3:0]        i_ctrl,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_ovf,
    output logic              o_illegal
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_slt;
    logic              w_add_ovf;
    logic              w_sub_ovf;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_slt  = $signed(i_a) < $signed(i_b);

    // Signed overflow: add overflows when like-signed operands give a
    // different sign; subtract when unlike-signed operands flip src1's sign.
    assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1]  != i_a[DATA_W-1]);
    assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);

    // Operation select; address adds and BEQ compare never flag overflow
    always_comb begin
        o_result  = '0;
        o_ovf     = 1'b0;
        o_illegal = 1'b0;
        case (i_ctrl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: begin
                o_result = w_sum;
                o_ovf    = w_add_ovf;
            end
            ALU_SUB: begin
                o_result = w_diff;
                o_ovf    = w_sub_ovf;
            end
            ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_slt};
            ALU_LW:  o_result = w_sum;
            ALU_SW:  o_result = w_sum;
            ALU_BEQ: o_result = w_diff;
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU plus one-entry EX/MEM register with valid/ready handshake.
// Latency: 1 cycle from accept to out_valid_o; 1 entry/cycle when drained.
// Backpressure: in_ready_o = !out_valid_o || out_ready_i; held entry stable while stalled.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_W  = ALU_REG_W
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              branch_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [REG_W-1:0]  rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              illegal_o,
    output logic              branch_taken_o
);

    ex_state_e         r_state;
    ex_state_e         w_state_nxt;
    logic              w_accept;
    logic              w_in_ready;
    logic              w_out_valid;

    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic              w_ovf;
    logic              w_illegal;

    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_rd_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_zero;
    logic              r_ovf;
    logic              r_illegal;
    logic              r_branch_taken;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_ctrl    (alu_ctrl_i),
        .i_a       (src1_i),
        .i_b       (src2_i),
        .o_result  (w_result),
        .o_zero    (w_zero),
        .o_ovf     (w_ovf),
        .o_illegal (w_illegal)
    );

    // State register; reset drops any held entry without waiting for a clock
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake and next state; flush overrides both drain and accept
    always_comb begin
        w_out_valid = (r_state == ST_FULL);
        w_in_ready  = !w_out_valid || out_ready_i;
        w_accept    = in_valid_i && w_in_ready && !flush_i;
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && out_ready_i) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // EX/MEM payload: loads only on accept, with controls qualified so that
    // an illegal code becomes a flagged bubble and overflow blocks writeback
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_result       <= '0;
            r_wdata        <= '0;
            r_rd_addr      <= '0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_zero         <= 1'b0;
            r_ovf          <= 1'b0;
            r_illegal      <= 1'b0;
            r_branch_taken <= 1'b0;
        end else if (w_accept) begin
            r_result       <= w_result;
            r_wdata        <= wdata_i;
            r_rd_addr      <= rd_addr_i;
            r_reg_write    <= reg_write_i && !w_ovf && !w_illegal;
            r_mem_read     <= mem_read_i && !w_illegal;
            r_mem_write    <= mem_write_i && !w_illegal;
            r_zero         <= w_zero;
            r_ovf          <= w_ovf;
            r_illegal      <= w_illegal;
            r_branch_taken <= branch_i && (alu_ctrl_i == ALU_BEQ) && w_zero;
        end
    end

    assign in_ready_o     = w_in_ready;
    assign out_valid_o    = w_out_valid;
    assign result_o       = r_result;
    assign wdata_o        = r_wdata;
    assign rd_addr_o      = r_rd_addr;
    assign reg_write_o    = r_reg_write;
    assign mem_read_o     = r_mem_read;
    assign mem_write_o    = r_mem_write;
    assign zero_o         = r_zero;
    assign ovf_o          = r_ovf;
    assign illegal_o      = r_illegal;
    assign branch_taken_o = r_branch_taken;

endmodule
